// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and the misalignment rule for the memory arbiter
package risc_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } op_enum_dmem_size;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } arb_grant_e;

    function automatic logic is_misaligned(input op_enum_dmem_size size, input logic [1:0] addr_lo);
        case (size)
            HALF:    return addr_lo[0];
            WORD:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane strobe/write replication and load extraction
module mem_lane_align
    import risc_pkg::*;
(
    input  logic             is_fetch,
    input  op_enum_dmem_size size,
    input  logic [1:0]       addr_lo,
    input  logic             zero_ex,
    input  logic [31:0]      wdata,
    input  logic [31:0]      rdata,
    output logic [3:0]       strb,
    output logic [31:0]      wdata_rep,
    output logic [31:0]      rdata_ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
        strb      = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        // Fetches are always whole-word reads regardless of the data-side size.
        if (!is_fetch) begin
            case (size)
                BYTE: begin
                    strb      = 4'b0001 << addr_lo;
                    wdata_rep = {4{wdata[7:0]}};
                    rdata_ext = {{24{byte_lane[7] & ~zero_ex}}, byte_lane};
                end
                HALF: begin
                    strb      = 4'b0011 << addr_lo;
                    wdata_rep = {2{wdata[15:0]}};
                    rdata_ext = {{16{half_lane[15] & ~zero_ex}}, half_lane};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter onto a single memory bus
module mem_arbiter
    import risc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic [31:0]      if_rdata,
    output logic             if_done,
    input  logic             d_req,
    input  logic             d_wr,
    input  op_enum_dmem_size d_size,
    input  logic             d_zero_ex,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic [31:0]      d_rdata,
    output logic             d_done,
    output logic             d_err,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic             bus_wr,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wdata,
    output logic [3:0]       bus_strb,
    input  logic             bus_rvalid,
    input  logic [31:0]      bus_rdata,
    output logic             stall
);

    arb_state_e       state_q, state_d;
    arb_grant_e       last_grant_q, last_grant_d;
    op_enum_dmem_size size_q, size_d;
    logic             zero_ex_q, zero_ex_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic             bus_valid_q, bus_valid_d;
    logic             bus_wr_q, bus_wr_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_strb_q, bus_strb_d;
    logic             if_done_q, if_done_d;
    logic             d_done_q, d_done_d;
    logic             d_err_q, d_err_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;

    logic             pick_data;
    logic             d_mis;
    logic             is_idle;
    logic             al_is_fetch;
    op_enum_dmem_size al_size;
    logic [1:0]       al_addr_lo;
    logic [3:0]       al_strb;
    logic [31:0]      al_wdata;
    logic [31:0]      al_rdata;

    // Data wins a tie only when fetch held the previous grant.
    assign pick_data = d_req & (~if_req | (last_grant_q == GNT_FETCH));
    assign d_mis     = is_misaligned(d_size, d_addr[1:0]);
    assign is_idle   = (state_q == ARB_IDLE);

    // One aligner serves both phases: live operands while granting, latched ones while reading back.
    assign al_is_fetch = is_idle ? ~pick_data : (last_grant_q == GNT_FETCH);
    assign al_size     = is_idle ? d_size : size_q;
    assign al_addr_lo  = is_idle ? d_addr[1:0] : addr_lo_q;

    mem_lane_align u_lane_align (
        .is_fetch  (al_is_fetch),
        .size      (al_size),
        .addr_lo   (al_addr_lo),
        .zero_ex   (zero_ex_q),
        .wdata     (d_wdata),
        .rdata     (bus_rdata),
        .strb      (al_strb),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        size_d       = size_q;
        zero_ex_d    = zero_ex_q;
        addr_lo_d    = addr_lo_q;
        bus_valid_d  = bus_valid_q;
        bus_wr_d     = bus_wr_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_strb_d   = bus_strb_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        d_err_d      = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (if_req | d_req) begin
                    if (pick_data) begin
                        last_grant_d = GNT_DATA;
                        if (d_mis) begin
                            state_d  = ARB_DONE;
                            d_done_d = 1'b1;
                            d_err_d  = 1'b1;
                        end else begin
                            state_d     = ARB_REQ;
                            size_d      = d_size;
                            zero_ex_d   = d_zero_ex;
                            addr_lo_d   = d_addr[1:0];
                            bus_valid_d = 1'b1;
                            bus_wr_d    = d_wr;
                            bus_addr_d  = {d_addr[31:2], 2'b00};
                            bus_wdata_d = al_wdata;
                            bus_strb_d  = al_strb;
                        end
                    end else begin
                        last_grant_d = GNT_FETCH;
                        state_d      = ARB_REQ;
                        size_d       = WORD;
                        zero_ex_d    = 1'b0;
                        addr_lo_d    = 2'b00;
                        bus_valid_d  = 1'b1;
                        bus_wr_d     = 1'b0;
                        bus_addr_d   = if_addr & 32'hFFFF_FFFC;
                        bus_wdata_d  = 32'h0;
                        bus_strb_d   = 4'b1111;
                    end
                end
            end
            ARB_REQ: begin
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    if (bus_wr_q) begin
                        state_d  = ARB_DONE;
                        d_done_d = 1'b1;
                    end else begin
                        state_d = ARB_RESP;
                    end
                end
            end
            ARB_RESP: begin
                if (bus_rvalid) begin
                    state_d = ARB_DONE;
                    if (last_grant_q == GNT_DATA) begin
                        d_rdata_d = al_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = al_rdata;
                        if_done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GNT_FETCH;
            size_q       <= BYTE;
            zero_ex_q    <= 1'b0;
            addr_lo_q    <= 2'b00;
            bus_valid_q  <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            bus_strb_q   <= 4'h0;
            if_rdata_q   <= 32'h0;
            d_rdata_q    <= 32'h0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            size_q       <= size_d;
            zero_ex_q    <= zero_ex_d;
            addr_lo_q    <= addr_lo_d;
            bus_valid_q  <= bus_valid_d;
            bus_wr_q     <= bus_wr_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_strb_q   <= bus_strb_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
            d_err_q      <= d_err_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;
    assign bus_valid = bus_valid_q;
    assign bus_wr    = bus_wr_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_strb  = bus_strb_q;
    assign stall     = (if_req & ~if_done_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import risc_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             if_req;
    logic [31:0]      if_addr;
    logic [31:0]      if_rdata;
    logic             if_done;
    logic             d_req;
    logic             d_wr;
    op_enum_dmem_size d_size;
    logic             d_zero_ex;
    logic [31:0]      d_addr;
    logic [31:0]      d_wdata;
    logic [31:0]      d_rdata;
    logic             d_done;
    logic             d_err;
    logic             bus_valid;
    logic             bus_ready;
    logic             bus_wr;
    logic [31:0]      bus_addr;
    logic [31:0]      bus_wdata;
    logic [3:0]       bus_strb;
    logic             bus_rvalid;
    logic [31:0]      bus_rdata;
    logic             stall;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;

    typedef struct {
        logic        saw_valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        wr;
        int          lat;
        logic        got_i;
        logic        got_d;
        logic        err;
        logic [31:0] rdata;
        logic        stable;
        logic        stall_ok;
    } obs_t;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .d_req      (d_req),
        .d_wr       (d_wr),
        .d_size     (d_size),
        .d_zero_ex  (d_zero_ex),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .d_err      (d_err),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_wr     (bus_wr),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_strb   (bus_strb),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .stall      (stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_strb(input logic fetch, input logic [1:0] size, input logic [31:0] a);
        int lane;
        lane = int'(a % 4);
        if (fetch || size == 2'd2) return 4'hF;
        if (size == 2'd0) return 4'(1 << lane);
        return 4'(3 << lane);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] size, input logic zx, input logic [31:0] a, input logic [31:0] w);
        longint v;
        longint sh;
        sh = longint'(w) >> (8 * (a % 4));
        if (size == 2'd2) return w;
        if (size == 2'd0) begin
            v = sh % 256;
            if (!zx && v >= 128) v = v - 256;
        end else begin
            v = sh % 65536;
            if (!zx && v >= 32768) v = v - 65536;
        end
        return v[31:0];
    endfunction

    function automatic logic exp_mis(input logic fetch, input logic [1:0] size, input logic [31:0] a);
        if (fetch) return 1'b0;
        if (size == 2'd1) return (a % 2) != 0;
        if (size == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // Drives one request on a single port and plays the bus slave; it only observes, the tests judge.
    task automatic run_xfer(input logic fetch, input logic wr, input logic [1:0] size, input logic zx,
                            input logic [31:0] addr, input logic [31:0] wdata, input int rdy_wait,
                            input int rv_wait, input logic [31:0] rdata, output obs_t o);
        int   vc;
        int   rc;
        logic hs;
        logic wr_eff;
        o = '{default: 0};
        o.stable   = 1'b1;
        o.stall_ok = 1'b1;
        o.lat      = -1;
        vc = 0;
        rc = 0;
        hs = 1'b0;
        wr_eff = fetch ? 1'b0 : wr;
        if (fetch) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            d_req     = 1'b1;
            d_wr      = wr;
            d_size    = op_enum_dmem_size'(size);
            d_zero_ex = zx;
            d_addr    = addr;
            d_wdata   = wdata;
        end
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick();
            if (if_done || d_done) begin
                o.lat   = cyc;
                o.got_i = if_done;
                o.got_d = d_done;
                o.err   = d_err;
                o.rdata = fetch ? if_rdata : d_rdata;
                if (stall) o.stall_ok = 1'b0;
                break;
            end
            if (!stall) o.stall_ok = 1'b0;
            if (bus_valid) begin
                if (!o.saw_valid) begin
                    o.saw_valid = 1'b1;
                    o.addr  = bus_addr;
                    o.wdata = bus_wdata;
                    o.strb  = bus_strb;
                    o.wr    = bus_wr;
                end else if (bus_addr !== o.addr || bus_wdata !== o.wdata ||
                             bus_strb !== o.strb || bus_wr !== o.wr) begin
                    o.stable = 1'b0;
                end
                vc++;
                bus_ready  = (vc > rdy_wait);
                hs         = bus_ready;
                bus_rvalid = 1'($urandom_range(0, 1));
                bus_rdata  = $urandom;
            end else if (hs && !wr_eff) begin
                rc++;
                bus_ready  = 1'b0;
                bus_rvalid = (rc > rv_wait);
                bus_rdata  = bus_rvalid ? rdata : $urandom;
            end else begin
                bus_ready  = 1'b0;
                bus_rvalid = 1'($urandom_range(0, 1));
                bus_rdata  = $urandom;
            end
        end
        if_req     = 1'b0;
        d_req      = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_size = BYTE; d_zero_ex = 1'b0;
        d_addr = '0; d_wdata = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        tick();
        tick();
        tests_run++;
        if ({if_rdata, d_rdata, bus_addr, bus_wdata} !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h %h %h %h, expected all zero", if_rdata, d_rdata, bus_addr, bus_wdata);
        end
        tests_run++;
        if ({if_done, d_done, d_err, bus_valid, bus_wr, bus_strb, stall} !== 10'h0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b, expected 0", {if_done, d_done, d_err, bus_valid, bus_wr, bus_strb, stall});
        end
        rst = 1'b0;
        m_if_rdata = '0;
        m_d_rdata  = '0;
        tick();
    endtask

    task automatic test_fetch();
        obs_t o;
        run_xfer(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, o);
        m_if_rdata = 32'hDEADBEEF;
        tests_run++;
        if ({o.addr, o.strb, o.wr} !== {32'h100, 4'hF, 1'b0}) begin
            tests_failed++;
            $display("FAIL fetch_bus: got %h %h %b, expected 100 f 0", o.addr, o.strb, o.wr);
        end
        tests_run++;
        if (o.lat !== 3 || {o.got_i, o.got_d} !== 2'b10 || o.rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL fetch_done: got lat %0d i%b d%b %h, expected lat 3 i1 d0 deadbeef", o.lat, o.got_i, o.got_d, o.rdata);
        end
        tests_run++;
        if (if_rdata !== m_if_rdata || if_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_hold: got %h done %b, expected %h done 0", if_rdata, if_done, m_if_rdata);
        end
    endtask

    task automatic test_store_byte();
        obs_t o;
        run_xfer(1'b0, 1'b1, 2'd0, 1'b0, 32'h203, 32'h0000_00A5, 0, 0, 32'h0, o);
        tests_run++;
        if ({o.addr, o.strb, o.wdata, o.wr} !== {32'h200, 4'b1000, 32'hA5A5A5A5, 1'b1}) begin
            tests_failed++;
            $display("FAIL sb_bus: got %h %b %h %b, expected 200 1000 a5a5a5a5 1", o.addr, o.strb, o.wdata, o.wr);
        end
        tests_run++;
        if (o.lat !== 2 || {o.got_i, o.got_d, o.err} !== 3'b010) begin
            tests_failed++;
            $display("FAIL sb_done: got lat %0d i%b d%b e%b, expected lat 2 i0 d1 e0", o.lat, o.got_i, o.got_d, o.err);
        end
    endtask

    task automatic test_loads();
        obs_t o;
        run_xfer(1'b0, 1'b0, 2'd0, 1'b0, 32'h1, 32'h0, 0, 0, 32'h0000_8000, o);
        tests_run++;
        if (o.rdata !== 32'hFFFFFF80 || o.lat !== 3) begin
            tests_failed++;
            $display("FAIL lb: got %h lat %0d, expected ffffff80 lat 3", o.rdata, o.lat);
        end
        run_xfer(1'b0, 1'b0, 2'd0, 1'b1, 32'h1, 32'h0, 0, 0, 32'h0000_8000, o);
        tests_run++;
        if (o.rdata !== 32'h0000_0080) begin
            tests_failed++;
            $display("FAIL lbu: got %h, expected 00000080", o.rdata);
        end
        run_xfer(1'b0, 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 0, 0, 32'hBEEF_0000, o);
        tests_run++;
        if (o.rdata !== 32'h0000_BEEF || o.strb !== 4'b1100) begin
            tests_failed++;
            $display("FAIL lhu: got %h strb %b, expected 0000beef strb 1100", o.rdata, o.strb);
        end
        m_d_rdata = 32'h0000_BEEF;
    endtask

    task automatic test_misalign();
        obs_t o;
        run_xfer(1'b0, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 0, 0, 32'h1234_5678, o);
        tests_run++;
        if (o.lat !== 1 || {o.saw_valid, o.got_d, o.err} !== 3'b011) begin
            tests_failed++;
            $display("FAIL lw_misalign: got lat %0d v%b d%b e%b, expected lat 1 v0 d1 e1", o.lat, o.saw_valid, o.got_d, o.err);
        end
        tests_run++;
        if (o.rdata !== m_d_rdata) begin
            tests_failed++;
            $display("FAIL misalign_rdata: got %h, expected %h", o.rdata, m_d_rdata);
        end
    endtask

    task automatic test_ready_hold();
        obs_t o;
        run_xfer(1'b0, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 5, 0, 32'hCAFE_F00D, o);
        m_d_rdata = 32'hCAFE_F00D;
        tests_run++;
        if ({o.saw_valid, o.stable, o.stall_ok} !== 3'b111 || o.lat !== 8) begin
            tests_failed++;
            $display("FAIL ready_hold: got v%b s%b st%b lat %0d, expected v1 s1 st1 lat 8", o.saw_valid, o.stable, o.stall_ok, o.lat);
        end
        tests_run++;
        if (o.rdata !== m_d_rdata) begin
            tests_failed++;
            $display("FAIL ready_hold_rdata: got %h, expected %h", o.rdata, m_d_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic exp_d;
        int   n;
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h1000;
        d_req = 1'b1; d_wr = 1'b0; d_size = WORD; d_zero_ex = 1'b0; d_addr = 32'h2000;
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        rst = 1'b0;
        exp_d = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 8; cyc++) begin
            tick();
            if (if_done || d_done) begin
                tests_run++;
                if ({d_done, if_done} !== {exp_d, ~exp_d}) begin
                    tests_failed++;
                    $display("FAIL rr_grant%0d: got d%b i%b, expected d%b i%b", n, d_done, if_done, exp_d, ~exp_d);
                end
                exp_d = ~exp_d;
                n++;
            end
        end
        tests_run++;
        if (n !== 8) begin
            tests_failed++;
            $display("FAIL rr_timeout: got %0d completions, expected 8", n);
        end
        if_req = 1'b0; d_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        tick();
        tick();
        m_if_rdata = 32'h1234_5678;
        m_d_rdata  = 32'h1234_5678;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic seen_done;
        d_req = 1'b1; d_wr = 1'b0; d_size = WORD; d_zero_ex = 1'b0; d_addr = 32'h40;
        bus_ready = 1'b1; bus_rvalid = 1'b0;
        tick();
        tests_run++;
        if (bus_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_valid: got %b, expected 1", bus_valid);
        end
        bus_ready = 1'b0;
        tick();
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({if_rdata, d_rdata, bus_addr, bus_valid, if_done, d_done, d_err} !== 100'h0) begin
            tests_failed++;
            $display("FAIL rmid_async: got %h %h %h %b%b%b%b, expected zeros", if_rdata, d_rdata, bus_addr, bus_valid, if_done, d_done, d_err);
        end
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = $urandom;
            tick();
            if (if_done || d_done || bus_valid || d_rdata != 0 || if_rdata != 0) seen_done = 1'b1;
        end
        bus_rvalid = 1'b0;
        tests_run++;
        if (seen_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_quiet: got activity %b, expected 0", seen_done);
        end
        m_if_rdata = '0;
        m_d_rdata  = '0;
        run_xfer(1'b0, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 0, 0, 32'h0BAD_CAFE, o);
        m_d_rdata = 32'h0BAD_CAFE;
        tests_run++;
        if (o.lat !== 3 || o.rdata !== m_d_rdata) begin
            tests_failed++;
            $display("FAIL rmid_recover: got lat %0d %h, expected lat 3 %h", o.lat, o.rdata, m_d_rdata);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        fetch, wr, zx, mis;
        logic [1:0]  size;
        logic [31:0] addr, wdata, rd, exp_rd;
        int          rw, vw, exp_lat;
        for (int i = 0; i < 40; i++) begin
            fetch = ($urandom_range(0, 3) == 0);
            wr    = fetch ? 1'b0 : 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 2));
            zx    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
            rd    = $urandom;
            rw    = $urandom_range(0, 3);
            vw    = $urandom_range(0, 3);
            mis   = exp_mis(fetch, size, addr);
            run_xfer(fetch, wr, size, zx, addr, wdata, rw, vw, rd, o);
            exp_lat = mis ? 1 : (wr ? rw + 2 : rw + vw + 3);
            if (fetch) m_if_rdata = rd;
            else if (!wr && !mis) m_d_rdata = exp_load(size, zx, addr, rd);
            exp_rd = fetch ? m_if_rdata : m_d_rdata;
            tests_run++;
            if (o.lat !== exp_lat || {o.got_i, o.got_d} !== {fetch, ~fetch} || o.err !== mis) begin
                tests_failed++;
                $display("FAIL rnd%0d_done: got lat %0d i%b d%b e%b, expected lat %0d i%b d%b e%b",
                         i, o.lat, o.got_i, o.got_d, o.err, exp_lat, fetch, ~fetch, mis);
            end
            tests_run++;
            if (o.rdata !== exp_rd) begin
                tests_failed++;
                $display("FAIL rnd%0d_rdata: got %h, expected %h", i, o.rdata, exp_rd);
            end
            tests_run++;
            if (o.saw_valid !== ~mis || o.stable !== 1'b1 || o.stall_ok !== 1'b1) begin
                tests_failed++;
                $display("FAIL rnd%0d_handshake: got v%b s%b st%b, expected v%b s1 st1", i, o.saw_valid, o.stable, o.stall_ok, ~mis);
            end
            if (!mis) begin
                tests_run++;
                if ({o.addr, o.strb, o.wr} !== {addr & 32'hFFFF_FFFC, exp_strb(fetch, size, addr), wr}) begin
                    tests_failed++;
                    $display("FAIL rnd%0d_bus: got %h %b %b, expected %h %b %b", i, o.addr, o.strb, o.wr,
                             addr & 32'hFFFF_FFFC, exp_strb(fetch, size, addr), wr);
                end
                if (wr) begin
                    tests_run++;
                    if (o.wdata !== exp_wdata(size, wdata)) begin
                        tests_failed++;
                        $display("FAIL rnd%0d_wdata: got %h, expected %h", i, o.wdata, exp_wdata(size, wdata));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_byte();
        test_loads();
        test_misalign();
        test_ready_hold();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
